// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU one-hot ops, forward selects,
// branch and M-extension funct3 codes, and the multiply/divide FSM states.
package ex_pkg;

  localparam int ALU_W      = 11;
  localparam int ALU_ADD    = 0;
  localparam int ALU_SUB    = 1;
  localparam int ALU_SLL    = 2;
  localparam int ALU_SLT    = 3;
  localparam int ALU_SLTU   = 4;
  localparam int ALU_XOR    = 5;
  localparam int ALU_SRL    = 6;
  localparam int ALU_SRA    = 7;
  localparam int ALU_OR     = 8;
  localparam int ALU_AND    = 9;
  localparam int ALU_PASS_B = 10;

  localparam logic [ALU_W-1:0] OH_ADD    = ALU_W'(1) << ALU_ADD;
  localparam logic [ALU_W-1:0] OH_SUB    = ALU_W'(1) << ALU_SUB;
  localparam logic [ALU_W-1:0] OH_SLL    = ALU_W'(1) << ALU_SLL;
  localparam logic [ALU_W-1:0] OH_SLT    = ALU_W'(1) << ALU_SLT;
  localparam logic [ALU_W-1:0] OH_SLTU   = ALU_W'(1) << ALU_SLTU;
  localparam logic [ALU_W-1:0] OH_XOR    = ALU_W'(1) << ALU_XOR;
  localparam logic [ALU_W-1:0] OH_SRL    = ALU_W'(1) << ALU_SRL;
  localparam logic [ALU_W-1:0] OH_SRA    = ALU_W'(1) << ALU_SRA;
  localparam logic [ALU_W-1:0] OH_OR     = ALU_W'(1) << ALU_OR;
  localparam logic [ALU_W-1:0] OH_AND    = ALU_W'(1) << ALU_AND;
  localparam logic [ALU_W-1:0] OH_PASS_B = ALU_W'(1) << ALU_PASS_B;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M unit: unsigned shift/add multiply and restoring divide on
// operand magnitudes, with the sign applied to the result in DONE.
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MD_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic [XLEN-1:0] o_result,
  output logic [1:0]      o_state
);

  localparam int CW = $clog2(MD_ITERS + 1);

  md_state_e       r_state, w_next_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_b, r_hi, r_lo;
  logic            r_neg_q, r_neg_r;

  logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_hi_nx, w_lo_nx;
  logic [XLEN:0]   w_sum, w_shift, w_trial;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0] w_quo, w_rem;

  assign w_a_signed = (i_op == MD_MUL) || (i_op == MD_MULH) || (i_op == MD_MULHSU) ||
                      (i_op == MD_DIV) || (i_op == MD_REM);
  assign w_b_signed = (i_op == MD_MUL) || (i_op == MD_MULH) ||
                      (i_op == MD_DIV) || (i_op == MD_REM);
  assign w_a_neg    = w_a_signed & i_a[XLEN-1];
  assign w_b_neg    = w_b_signed & i_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -i_a : i_a;
  assign w_b_mag    = w_b_neg ? -i_b : i_b;

  // r_lo holds the multiplier (shifted out LSB first) or the dividend/quotient.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_trial = w_shift - {1'b0, r_b};
    if (r_op[2]) begin
      if (!w_trial[XLEN]) begin
        w_hi_nx = w_trial[XLEN-1:0];
        w_lo_nx = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nx = w_shift[XLEN-1:0];
        w_lo_nx = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_nx = w_sum[XLEN:1];
      w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  always_comb begin
    w_prod   = {r_hi, r_lo};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    w_quo    = r_neg_q ? -r_lo : r_lo;
    w_rem    = r_neg_r ? -r_hi : r_hi;
    case (r_op)
      MD_MUL:                      o_result = w_prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             o_result = w_quo;
      default:                     o_result = w_rem;
    endcase
  end

  // Stall protocol: o_busy high means the instruction in EX must hold; the
  // cycle it drops with i_valid still high is the one the result is taken.
  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    case (r_state)
      MD_IDLE: begin
        o_busy = i_valid;
        if (i_valid) w_next_state = MD_RUN;
      end
      MD_RUN: begin
        o_busy = 1'b1;
        if (r_cnt == CW'(1)) w_next_state = MD_DONE;
      end
      default: w_next_state = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == MD_IDLE && i_valid) begin
        r_cnt   <= CW'(MD_ITERS);
        r_op    <= i_op;
        r_b     <= w_b_mag;
        r_hi    <= '0;
        r_lo    <= w_a_mag;
        // A zero divisor keeps the all-ones quotient unsigned-looking.
        r_neg_q <= (w_a_neg ^ w_b_neg) & ~(i_op[2] && i_b == '0);
        r_neg_r <= w_a_neg;
      end else if (r_state == MD_RUN) begin
        r_cnt <= r_cnt - 1'b1;
        r_hi  <= w_hi_nx;
        r_lo  <= w_lo_nx;
      end
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, one-hot ALU, branch/jump resolution and
// the iterative M-extension unit feeding the MEM pipeline register.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MD_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [10:0]     alu_ctrl_E,
  input  logic [XLEN-1:0] alu_srcA_E,
  input  logic [XLEN-1:0] alu_srcB_E,
  input  logic            alu_src_imm_E,
  input  logic [1:0]      forwardA_E,
  input  logic [1:0]      forwardB_E,
  input  logic [XLEN-1:0] alu_result_M,
  input  logic [XLEN-1:0] result_W,
  input  logic [XLEN-1:0] imm_extended_E,
  input  logic [XLEN-1:0] pc_E,
  input  logic [XLEN-1:0] pc4_E,
  input  logic            jump_E,
  input  logic            jalr_E,
  input  logic            branch_E,
  input  logic [2:0]      br_funct3_E,
  input  logic            takenE,
  input  logic            md_valid_E,
  input  logic [2:0]      md_op_E,
  output logic [XLEN-1:0] alu_result_E,
  output logic [XLEN-1:0] write_data_E,
  output logic            redirect_E,
  output logic [XLEN-1:0] redirect_pc_E,
  output logic            md_busy_E
);

  logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_op_b, w_alu, w_target, w_md_result;
  logic [4:0]      w_shamt;
  logic            w_cond, w_actual;
  logic [1:0]      w_md_state;

  always_comb begin
    case (forwardA_E)
      FWD_W:   w_fwd_a = result_W;
      FWD_M:   w_fwd_a = alu_result_M;
      default: w_fwd_a = alu_srcA_E;
    endcase
    case (forwardB_E)
      FWD_W:   w_fwd_b = result_W;
      FWD_M:   w_fwd_b = alu_result_M;
      default: w_fwd_b = alu_srcB_E;
    endcase
  end

  assign w_op_b       = alu_src_imm_E ? imm_extended_E : w_fwd_b;
  assign write_data_E = w_fwd_b;
  assign w_shamt      = w_op_b[4:0];

  // Anything other than exactly one op bit is a flushed bubble.
  always_comb begin
    case (alu_ctrl_E)
      OH_ADD:    w_alu = w_fwd_a + w_op_b;
      OH_SUB:    w_alu = w_fwd_a - w_op_b;
      OH_SLL:    w_alu = w_fwd_a << w_shamt;
      OH_SLT:    w_alu = {{(XLEN-1){1'b0}}, $signed(w_fwd_a) < $signed(w_op_b)};
      OH_SLTU:   w_alu = {{(XLEN-1){1'b0}}, w_fwd_a < w_op_b};
      OH_XOR:    w_alu = w_fwd_a ^ w_op_b;
      OH_SRL:    w_alu = w_fwd_a >> w_shamt;
      OH_SRA:    w_alu = $signed(w_fwd_a) >>> w_shamt;
      OH_OR:     w_alu = w_fwd_a | w_op_b;
      OH_AND:    w_alu = w_fwd_a & w_op_b;
      OH_PASS_B: w_alu = w_op_b;
      default:   w_alu = '0;
    endcase
  end

  always_comb begin
    case (br_funct3_E)
      F3_BEQ:  w_cond = (w_fwd_a == w_fwd_b);
      F3_BNE:  w_cond = (w_fwd_a != w_fwd_b);
      F3_BLT:  w_cond = ($signed(w_fwd_a) < $signed(w_fwd_b));
      F3_BGE:  w_cond = ($signed(w_fwd_a) >= $signed(w_fwd_b));
      F3_BLTU: w_cond = (w_fwd_a < w_fwd_b);
      F3_BGEU: w_cond = (w_fwd_a >= w_fwd_b);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_actual      = jump_E | jalr_E | (branch_E & w_cond);
  assign w_target      = jalr_E ? ((w_fwd_a + imm_extended_E) & ~{{(XLEN-1){1'b0}}, 1'b1})
                                : (pc_E + imm_extended_E);
  assign redirect_E    = (branch_E & (w_actual != takenE)) | (jump_E & ~takenE) | jalr_E;
  assign redirect_pc_E = w_actual ? w_target : pc4_E;

  ex_muldiv #(
    .XLEN     (XLEN),
    .MD_ITERS (MD_ITERS)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (md_valid_E),
    .i_op     (md_op_E),
    .i_a      (w_fwd_a),
    .i_b      (w_fwd_b),
    .o_busy   (md_busy_E),
    .o_result (w_md_result),
    .o_state  (w_md_state)
  );

  always_comb begin
    if (md_valid_E && w_md_state == MD_DONE) alu_result_E = w_md_result;
    else if (jump_E | jalr_E)                alu_result_E = pc4_E;
    else                                     alu_result_E = w_alu;
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: literal checks per vector plus a cycle-level
// reference model compared against every output on each falling edge.
module tb_ex_stage;
  import ex_pkg::*;

  localparam int XLEN     = 32;
  localparam int MD_ITERS = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [10:0]     alu_ctrl_E;
  logic [XLEN-1:0] alu_srcA_E, alu_srcB_E, alu_result_M, result_W, imm_extended_E, pc_E, pc4_E;
  logic            alu_src_imm_E, jump_E, jalr_E, branch_E, takenE, md_valid_E;
  logic [1:0]      forwardA_E, forwardB_E;
  logic [2:0]      br_funct3_E, md_op_E;
  logic [XLEN-1:0] alu_result_E, write_data_E, redirect_pc_E;
  logic            redirect_E, md_busy_E;

  ex_stage #(.XLEN(XLEN), .MD_ITERS(MD_ITERS)) dut (
    .clk(clk), .rst(rst), .alu_ctrl_E(alu_ctrl_E), .alu_srcA_E(alu_srcA_E),
    .alu_srcB_E(alu_srcB_E), .alu_src_imm_E(alu_src_imm_E), .forwardA_E(forwardA_E),
    .forwardB_E(forwardB_E), .alu_result_M(alu_result_M), .result_W(result_W),
    .imm_extended_E(imm_extended_E), .pc_E(pc_E), .pc4_E(pc4_E), .jump_E(jump_E),
    .jalr_E(jalr_E), .branch_E(branch_E), .br_funct3_E(br_funct3_E), .takenE(takenE),
    .md_valid_E(md_valid_E), .md_op_E(md_op_E), .alu_result_E(alu_result_E),
    .write_data_E(write_data_E), .redirect_E(redirect_E), .redirect_pc_E(redirect_pc_E),
    .md_busy_E(md_busy_E)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] r);
    if (sel == 2'b01) return result_W;
    if (sel == 2'b10) return alu_result_M;
    return r;
  endfunction

  function automatic logic [31:0] m_alu(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b);
    int ia = a;
    int ib = b;
    if ($countones(op) != 1) return 32'd0;
    if (op[0])  return a + b;
    if (op[1])  return a - b;
    if (op[2])  return a << b[4:0];
    if (op[3])  return (ia < ib) ? 32'd1 : 32'd0;
    if (op[4])  return (a < b) ? 32'd1 : 32'd0;
    if (op[5])  return a ^ b;
    if (op[6])  return a >> b[4:0];
    if (op[7])  return ia >>> b[4:0];
    if (op[8])  return a | b;
    if (op[9])  return a & b;
    return b;
  endfunction

  function automatic logic [31:0] m_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int ia = a;
    int ib = b;
    logic signed [63:0] sa = ia;
    logic signed [63:0] sb = ib;
    logic signed [63:0] ua = {32'd0, a};
    logic signed [63:0] ub = {32'd0, b};
    logic [63:0] p;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int ia = a;
    int ib = b;
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return ia < ib;
      3'b101:  return ia >= ib;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // md_cyc counts cycles since an M op was accepted; 0 = no op in flight.
  int          md_cyc = 0;
  logic [31:0] md_exp;
  always @(posedge clk) begin
    if (rst) md_cyc = 0;
    else if (md_cyc == 0) begin
      if (md_valid_E) begin
        md_cyc = 1;
        md_exp = m_md(md_op_E, m_fwd(forwardA_E, alu_srcA_E), m_fwd(forwardB_E, alu_srcB_E));
      end
    end else if (md_cyc == MD_ITERS + 1) md_cyc = 0;
    else md_cyc++;
  end

  // scoreboard compare, every falling edge outside reset
  always @(negedge clk) begin
    logic [31:0] fa, fb, ob, tgt;
    logic        act, exp_busy;
    if (!rst) begin
      fa  = m_fwd(forwardA_E, alu_srcA_E);
      fb  = m_fwd(forwardB_E, alu_srcB_E);
      ob  = alu_src_imm_E ? imm_extended_E : fb;
      act = jump_E | jalr_E | (branch_E & m_cond(br_funct3_E, fa, fb));
      tgt = jalr_E ? ((fa + imm_extended_E) & 32'hFFFF_FFFE) : (pc_E + imm_extended_E);
      exp_busy = (md_cyc == 0) ? md_valid_E : (md_cyc <= MD_ITERS);
      check("sb_write_data", write_data_E, fb);
      check("sb_redirect", 32'(redirect_E),
            32'((branch_E && (act != takenE)) || (jump_E && !takenE) || jalr_E));
      check("sb_redirect_pc", redirect_pc_E, act ? tgt : pc4_E);
      check("sb_busy", 32'(md_busy_E), 32'(exp_busy));
      if (md_valid_E) begin
        if (md_cyc == MD_ITERS + 1) check("sb_md_result", alu_result_E, md_exp);
      end else begin
        check("sb_alu_result", alu_result_E, (jump_E || jalr_E) ? pc4_E : m_alu(alu_ctrl_E, fa, ob));
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    alu_ctrl_E = '0; alu_srcA_E = '0; alu_srcB_E = '0; alu_src_imm_E = 1'b0;
    forwardA_E = 2'b00; forwardB_E = 2'b00; alu_result_M = '0; result_W = '0;
    imm_extended_E = '0; pc_E = 32'h100; pc4_E = 32'h104; jump_E = 1'b0; jalr_E = 1'b0;
    branch_E = 1'b0; br_funct3_E = 3'b000; takenE = 1'b0; md_valid_E = 1'b0; md_op_E = 3'b000;
  endtask

  task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int busy_n = 0;
    bit done   = 1'b0;
    next_cycle();
    clear();
    md_valid_E = 1'b1; md_op_E = op; alu_srcA_E = a; alu_srcB_E = b;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (md_busy_E) begin
        busy_n++;
        if (busy_n == 2) begin
          alu_srcA_E = $urandom;
          alu_srcB_E = $urandom_range(1, 1000);
        end
      end else done = 1'b1;
    end
    check({name, "_finished"}, 32'(done), 32'd1);
    check({name, "_busy_cycles"}, busy_n, MD_ITERS + 1);
    check({name, "_result"}, alu_result_E, exp);
    next_cycle();
    md_valid_E = 1'b0;
  endtask

  initial begin
    clear();
    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(md_busy_E), 32'd0);
    check("reset_bubble", alu_result_E, 32'd0);

    next_cycle(); clear();
    alu_ctrl_E = OH_ADD; forwardA_E = 2'b10; alu_result_M = 32'd5; alu_srcB_E = 32'd7;
    @(negedge clk);
    check("add_fwd_m", alu_result_E, 32'd12);

    next_cycle(); clear();
    alu_ctrl_E = OH_SLT; forwardA_E = 2'b10; alu_result_M = 32'hFFFF_FFFF; alu_srcB_E = 32'd1;
    @(negedge clk);
    check("slt_neg", alu_result_E, 32'd1);
    alu_ctrl_E = OH_SLTU;
    @(negedge clk);
    check("sltu_big", alu_result_E, 32'd0);

    next_cycle(); clear();
    alu_ctrl_E = OH_SRA; alu_srcA_E = 32'h8000_0000; alu_src_imm_E = 1'b1;
    imm_extended_E = 32'h0000_0024; alu_srcB_E = 32'd9;
    @(negedge clk);
    check("sra_imm_shamt", alu_result_E, 32'hF800_0000);
    check("store_data", write_data_E, 32'd9);

    next_cycle(); clear();
    alu_ctrl_E = OH_SUB; alu_srcA_E = 32'd10; forwardB_E = 2'b01; result_W = 32'd3;
    forwardA_E = 2'b11;
    @(negedge clk);
    check("sub_fwd_w_fa11", alu_result_E, 32'd7);
    alu_ctrl_E = OH_ADD | OH_OR;
    @(negedge clk);
    check("multihot_bubble", alu_result_E, 32'd0);

    next_cycle(); clear();
    alu_ctrl_E = OH_PASS_B; alu_src_imm_E = 1'b1; imm_extended_E = 32'h1234_5000;
    @(negedge clk);
    check("lui_pass_b", alu_result_E, 32'h1234_5000);

    next_cycle(); clear();
    branch_E = 1'b1; br_funct3_E = F3_BEQ; alu_srcA_E = 32'd3; alu_srcB_E = 32'd3;
    pc_E = 32'h100; pc4_E = 32'h104; imm_extended_E = 32'h20;
    @(negedge clk);
    check("beq_taken_redirect", 32'(redirect_E), 32'd1);
    check("beq_taken_pc", redirect_pc_E, 32'h120);
    alu_srcB_E = 32'd4; takenE = 1'b1;
    @(negedge clk);
    check("beq_nt_redirect", 32'(redirect_E), 32'd1);
    check("beq_nt_pc", redirect_pc_E, 32'h104);
    br_funct3_E = F3_BLT; alu_srcA_E = 32'hFFFF_FFF0;
    @(negedge clk);
    check("blt_predicted_ok", 32'(redirect_E), 32'd0);

    next_cycle(); clear();
    jalr_E = 1'b1; alu_srcA_E = 32'h203; imm_extended_E = 32'd0; pc4_E = 32'h108;
    @(negedge clk);
    check("jalr_redirect", 32'(redirect_E), 32'd1);
    check("jalr_pc", redirect_pc_E, 32'h202);
    check("jalr_link", alu_result_E, 32'h108);

    next_cycle(); clear();
    jump_E = 1'b1; takenE = 1'b1; imm_extended_E = 32'h40;
    @(negedge clk);
    check("jal_predicted", 32'(redirect_E), 32'd0);
    check("jal_pc", redirect_pc_E, 32'h140);

    run_md("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_md("rem_neg", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_md("mulh_min", MD_MULH, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF);
    run_md("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("divu_zero", MD_DIVU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
    run_md("rem_zero", MD_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run_md("div_zero", MD_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_md("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_md("remu", MD_REMU, 32'd13, 32'd5, 32'd3);

    next_cycle(); clear();
    md_valid_E = 1'b1; md_op_E = MD_MUL; alu_srcA_E = 32'd100; alu_srcB_E = 32'd3;
    repeat (5) @(negedge clk);
    check("mid_run_busy", 32'(md_busy_E), 32'd1);
    next_cycle();
    rst = 1'b1; md_valid_E = 1'b0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(md_busy_E), 32'd0);
    check("abort_no_result", alu_result_E, 32'd0);
    run_md("mul_after_reset", MD_MUL, 32'd6, 32'd7, 32'd42);

    next_cycle(); clear();
    repeat (2) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
